multi_evt_counter: RTL and testbench
====================================

MULTI_EVT_COUNTER -- requirements
Module: multi_evt_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels, 1..16.
REQ-002 SHALL have parameter WIDTH, default 16: bits per channel counter, 2..32.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at terminal, 1 = hold at terminal.
REQ-004 SHALL have parameter COUNT_START, default 0: per-channel reset value, must be < 2^WIDTH.
REQ-005 SHALL have port clk_in  input  1: sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst_in  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port evt_in  input  NUM_CH: per-channel count event, sampled each cycle.
REQ-008 SHALL have port dir_in  input  NUM_CH: per-channel direction, 0 = up, 1 = down.
REQ-009 SHALL have port load_in  input  NUM_CH: per-channel synchronous load strobe.
REQ-010 SHALL have port load_val_in  input  WIDTH: load value shared by all channels.
REQ-011 SHALL have port max_in  input  WIDTH: runtime terminal value shared by all channels; range 0..max_in.
REQ-012 SHALL have port count_out  output  NUM_CH*WIDTH: packed counts, channel k at bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port wrap_out  output  NUM_CH: per-channel registered terminal-event pulse.
REQ-014 SHALL have port any_wrap_out  output  1: registered OR of all wrap_out bits, same cycle as wrap_out.

Function
REQ-015 SHALL apply per-channel priority rst_in > load_in > effective event > hold.
REQ-016 SHALL on load set count to min(load_val_in, max_in), with no wrap pulse that cycle.
REQ-017 SHALL on up event with count < max_in increment by 1.
REQ-018 SHALL treat up event with count >= max_in as terminal: wrap mode -> 0; saturate mode -> max_in.
REQ-019 SHALL on down event with count > 0 decrement by 1; count > max_in first clamps to max_in, then decrements.
REQ-020 SHALL treat down event with count == 0 as terminal: wrap mode -> max_in; saturate mode -> 0.
REQ-021 SHALL assert wrap_out[k] for exactly the one cycle after a terminal event on channel k, in both modes.
REQ-022 SHALL with max_in == 0 keep count at 0 and make every event terminal (pulse per event).
REQ-023 SHALL keep all channels independent; simultaneous events on all channels update all in the same cycle.
REQ-024 SHALL show count changes on count_out one cycle after the causing input (single register stage, no combinational input-to-output path).
REQ-025 SHALL use no arithmetic wider than WIDTH+1 bits and SHALL never produce a count > max_in after any event or load.

Reset
REQ-026 SHALL on rst_in set every channel count to COUNT_START and clear wrap_out and any_wrap_out.
REQ-027 SHALL let rst_in override in-flight load or events that cycle; first update occurs in the cycle after rst_in deasserts.

Configuration
REQ-028 SHALL support macro MULTI_EVT_COUNTER_CASCADE_EN.
REQ-029 SHALL with the macro defined chain channels: effective event of channel k>0 = same-cycle terminal event of channel k-1; evt_in[k>0] ignored; dir_in[0] governs all channels; load_in still per channel.
REQ-030 SHALL with the macro undefined use effective event = evt_in[k] and dir_in[k] for every channel.

Verification
REQ-031 SHALL cover: NUM_CH=4, WIDTH=4, max_in=9, 10 up events on ch0 -> count 0..9 then 0, wrap_out[0] high 1 cycle after 10th event, any_wrap_out same cycle.
REQ-032 SHALL cover: SATURATE=1, max_in=5, ch1 down from 0 -> stays 0 with wrap_out[1] pulse; 7 up events -> holds at 5, pulse after 6th and 7th.
REQ-033 SHALL cover: load_in[2] with load_val_in=12, max_in=9 -> count 9; load and evt same cycle -> load wins, no pulse.
REQ-034 SHALL cover: rst_in asserted mid-count with evt_in all high, COUNT_START=3 -> all counts 3, wrap_out 0 next cycle.
REQ-035 SHALL cover: MULTI_EVT_COUNTER_CASCADE_EN, max_in=9, 100 ch0 events -> ch0=0, ch1=0, ch2=1, ch1 wrap pulse on 100th event.
REQ-036 SHALL cover: max_in reduced from 9 to 3 while ch3=7, one up event -> ch3=0 (wrap mode) with pulse.

Source files
------------

// File: rtl/multi_evt_counter.sv
`default_nettype none
// =============================================================================
// Module   : multi_evt_counter
// Purpose  : Bank of NUM_CH up/down event counters sharing a runtime terminal
//            value (max_in), with wrap or saturate behaviour and a registered
//            terminal-event pulse per channel. Optional channel chaining is
//            enabled by defining MULTI_EVT_COUNTER_CASCADE_EN.
// Revision : 1.0 - initial release
// =============================================================================
module multi_evt_counter #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int SATURATE    = 0,
  parameter int COUNT_START = 0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       dir_in,
  input  logic [NUM_CH-1:0]       load_in,
  input  logic [WIDTH-1:0]        load_val_in,
  input  logic [WIDTH-1:0]        max_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       wrap_out,
  output logic                    any_wrap_out
);

  localparam logic [WIDTH-1:0] C_START = WIDTH'(COUNT_START);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam bit               C_SAT   = (SATURATE != 0);

  logic [WIDTH-1:0]  w_load_clamped;
  logic [NUM_CH-1:0] w_term;
  logic              r_any;

  // Loads are clamped so a count can never exceed the terminal value.
  assign w_load_clamped = (load_val_in > max_in) ? max_in : load_val_in;

`ifdef MULTI_EVT_COUNTER_CASCADE_EN
  logic w_unused;
  assign w_unused = ^{evt_in, dir_in};
`endif

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic             w_evt;
      logic             w_dir;
      logic             w_at_top;
      logic             w_at_bot;
      logic             w_term_ch;
      logic [WIDTH-1:0] w_base;
      logic [WIDTH-1:0] w_next;
      logic [WIDTH-1:0] r_cnt;
      logic             r_wrap;

`ifdef MULTI_EVT_COUNTER_CASCADE_EN
      if (k == 0) begin : g_head
        assign w_evt = evt_in[0];
      end else begin : g_link
        // Each stage advances on the same-cycle terminal event of the previous one.
        assign w_evt = g_ch[k-1].w_term_ch;
      end
      assign w_dir = dir_in[0];
`else
      assign w_evt = evt_in[k];
      assign w_dir = dir_in[k];
`endif

      // A count above max_in (after max_in shrinks) is treated as sitting at max_in.
      assign w_at_top = (r_cnt >= max_in);
      assign w_base   = w_at_top ? max_in : r_cnt;
      assign w_at_bot = (w_base == '0);

      assign w_term_ch = w_evt & ~load_in[k] & (w_dir ? w_at_bot : w_at_top);
      assign w_term[k] = w_term_ch;

      always_comb begin
        w_next = r_cnt;
        if (w_dir) begin
          if (w_at_bot) w_next = C_SAT ? '0 : max_in;
          else          w_next = w_base - C_ONE;
        end else begin
          if (w_at_top) w_next = C_SAT ? max_in : '0;
          else          w_next = r_cnt + C_ONE;
        end
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_cnt  <= C_START;
          r_wrap <= 1'b0;
        end else begin
          r_wrap <= w_term_ch;
          if (load_in[k]) begin
            r_cnt <= w_load_clamped;
          end else if (w_evt) begin
            r_cnt <= w_next;
          end
        end
      end

      assign count_out[k*WIDTH +: WIDTH] = r_cnt;
      assign wrap_out[k]                 = r_wrap;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_term;
    end
  end

  assign any_wrap_out = r_any;

endmodule
`default_nettype wire

// File: tb/tb_multi_evt_counter.sv
`default_nettype none
// Scoreboard bench for multi_evt_counter: a wrap-mode instance (COUNT_START=3)
// and a saturate-mode instance, driven by directed vectors.
module tb_multi_evt_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  a_evt = '0, a_dir = '0, a_load = '0, a_lval = '0, a_max = 4'd9;
  logic [3:0]  b_evt = '0, b_dir = '0, b_load = '0, b_lval = '0, b_max = 4'd5;
  logic [15:0] a_count, b_count;
  logic [3:0]  a_wrap, b_wrap;
  logic        a_any, b_any;

  multi_evt_counter #(.NUM_CH(4), .WIDTH(4), .SATURATE(0), .COUNT_START(3)) u_wrap (
    .clk_in(clk), .rst_in(rst), .evt_in(a_evt), .dir_in(a_dir), .load_in(a_load),
    .load_val_in(a_lval), .max_in(a_max), .count_out(a_count), .wrap_out(a_wrap),
    .any_wrap_out(a_any)
  );

  multi_evt_counter #(.NUM_CH(4), .WIDTH(4), .SATURATE(1), .COUNT_START(0)) u_sat (
    .clk_in(clk), .rst_in(rst), .evt_in(b_evt), .dir_in(b_dir), .load_in(b_load),
    .load_val_in(b_lval), .max_in(b_max), .count_out(b_count), .wrap_out(b_wrap),
    .any_wrap_out(b_any)
  );

  typedef struct {
    bit          sel;
    logic [15:0] cnt;
    logic [3:0]  wrap;
    logic        any;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  // Drive one cycle of stimulus to the selected instance and queue its result.
  task automatic step(input bit sel, input logic r, input logic [3:0] evt,
                      input logic [3:0] dir, input logic [3:0] ld,
                      input logic [3:0] lval, input logic [3:0] mx,
                      input logic [15:0] ecnt, input logic [3:0] ewrap);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (!sel) begin
      a_evt = evt; a_dir = dir; a_load = ld; a_lval = lval; a_max = mx;
      b_evt = '0;  b_dir = '0;  b_load = '0;
    end else begin
      b_evt = evt; b_dir = dir; b_load = ld; b_lval = lval; b_max = mx;
      a_evt = '0;  a_dir = '0;  a_load = '0;
    end
    e.sel  = sel;
    e.cnt  = ecnt;
    e.wrap = ewrap;
    e.any  = (ewrap != 4'b0000);
    e.tag  = tag;
    tag++;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] gc;
    logic [3:0]  gw;
    logic        ga;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        gc = e.sel ? b_count : a_count;
        gw = e.sel ? b_wrap  : a_wrap;
        ga = e.sel ? b_any   : a_any;
        total++;
        if (gc !== e.cnt || gw !== e.wrap || ga !== e.any) begin
          bad++;
          $display("FAIL step%0d %s: count=%h wrap=%b any=%b, required count=%h wrap=%b any=%b",
                   e.tag, e.sel ? "sat" : "wrap", gc, gw, ga, e.cnt, e.wrap, e.any);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state of both instances, with events pending during reset.
    step(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd9, 16'h3333, 4'b0000);
    step(1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd5, 16'h0000, 4'b0000);
`ifdef MULTI_EVT_COUNTER_CASCADE_EN
    step(0, 0, 4'hF, 4'h0, 4'hF, 4'h0, 4'd9, 16'h0000, 4'b0000);
    for (int i = 1; i <= 100; i++) begin
      step(0, 0, 4'hF, 4'b1110, 4'h0, 4'h0, 4'd9,
           {4'h0, 4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)},
           {2'b00, (i % 100) == 0, (i % 10) == 0});
    end
`else
    // Load beats simultaneous events on every channel.
    step(0, 0, 4'hF, 4'h0, 4'hF, 4'h0, 4'd9, 16'h0000, 4'b0000);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'd9, {12'h000, 4'(i % 10)},
           (i == 10) ? 4'b0001 : 4'b0000);
    end
    step(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'd9, 16'h0000, 4'b0000);
    step(0, 0, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'd9, 16'h0009, 4'b0001);
    step(0, 0, 4'h0, 4'h0, 4'b0100, 4'hC, 4'd9, 16'h0909, 4'b0000);
    step(0, 0, 4'b0100, 4'h0, 4'b0100, 4'hC, 4'd9, 16'h0909, 4'b0000);
    step(0, 0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'd9, 16'h0009, 4'b0100);
    step(0, 0, 4'h0, 4'h0, 4'b1000, 4'd7, 4'd9, 16'h7009, 4'b0000);
    // max_in shrinks below the current count.
    step(0, 0, 4'b1000, 4'h0, 4'h0, 4'h0, 4'd3, 16'h0009, 4'b1000);
    step(0, 0, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'd3, 16'h0002, 4'b0000);
    // max_in of zero: every event is terminal.
    step(0, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'd0, 16'h0000, 4'b0001);
    step(0, 0, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'd0, 16'h0000, 4'b0001);
    step(0, 0, 4'h0, 4'h0, 4'b0010, 4'd5, 4'd0, 16'h0000, 4'b0000);
    // All channels at once, mixed directions.
    step(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd9, 16'h1111, 4'b0000);
    step(0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd9, 16'h0000, 4'b0000);
    step(0, 0, 4'hF, 4'b1010, 4'h0, 4'h0, 4'd9, 16'h9191, 4'b1010);
    // Reset mid-count, then first update right after release.
    step(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd9, 16'h3333, 4'b0000);
    step(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd9, 16'h4444, 4'b0000);
    // Saturating instance.
    step(1, 0, 4'b0010, 4'b0010, 4'h0, 4'h0, 4'd5, 16'h0000, 4'b0010);
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 4'b0010, 4'h0, 4'h0, 4'h0, 4'd5, {8'h00, 4'((i > 5) ? 5 : i), 4'h0},
           (i >= 6) ? 4'b0010 : 4'b0000);
    end
    step(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'd5, 16'h0050, 4'b0000);
    step(1, 0, 4'b0010, 4'b0010, 4'h0, 4'h0, 4'd5, 16'h0040, 4'b0000);
    step(1, 0, 4'b0010, 4'h0, 4'h0, 4'h0, 4'd2, 16'h0020, 4'b0010);
    step(1, 0, 4'b0010, 4'h0, 4'b0010, 4'hF, 4'd2, 16'h0020, 4'b0000);
    step(1, 0, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'd2, 16'h0020, 4'b0001);
`endif
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
